// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 8;
  localparam logic [FETCH_DATA_W-1:0] HALT_WORD = 8'hFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    FULL = 3'd4
  } fetch_state_e;

  function automatic logic is_halt_word(input logic [FETCH_DATA_W-1:0] word);
    return (word == HALT_WORD);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding {instruction, pc} pairs; flush empties it in one cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = FETCH_DATA_W + FETCH_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Outputs read as zero while empty so the head never shows stale entries.
  assign o_rdata   = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (i_flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// PC owner and instruction fetch front end with one-outstanding imem requests.
// Optional halt-word detection is enabled by defining FETCH_HALT_DETECT_EN.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] pc_out,
  output logic              imem_req,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     r_state;
  logic [ADDR_W-1:0] r_pc;
  logic             r_halted;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_count_after_push;
  logic             w_space_now;
  logic             w_space_after_push;
  logic             w_halt_hit;
  logic [DATA_W+ADDR_W-1:0] w_head;

  assign w_pop  = !w_empty && instr_ready;
  assign w_push = (r_state == WAIT) && imem_rvalid && !redirect_valid;

  // Occupancy after this cycle's push (WAIT) or pop decides whether the next fetch may start.
  assign w_count_after_push = w_count + CW'(1) - CW'(w_pop);
  assign w_space_after_push = (w_count_after_push < CW'(DEPTH));
  assign w_space_now        = !w_full || w_pop;

`ifdef FETCH_HALT_DETECT_EN
  assign w_halt_hit = w_push && is_halt_word(imem_rdata);
  assign halted     = r_halted;
`else
  assign w_halt_hit = 1'b0;
  assign halted     = 1'b0;
`endif

  fetch_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata ({imem_rdata, r_pc}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign pc_out      = r_pc;
  assign imem_req    = (r_state == REQ);
  assign instr_valid = !w_empty;
  assign instr_out   = w_head[DATA_W+ADDR_W-1:ADDR_W];
  assign instr_pc    = w_head[ADDR_W-1:0];

  // Fetch sequencer: PC, state and halt status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc;
      r_halted <= 1'b0;
      case (r_state)
        // The strobe goes out this cycle, so its response is still owed.
        REQ:        r_state <= DROP;
        WAIT, DROP: r_state <= imem_rvalid ? (run ? REQ : IDLE) : DROP;
        default:    r_state <= run ? REQ : IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (run && !r_halted) begin
            r_state <= w_space_now ? REQ : FULL;
          end else begin
            r_state <= IDLE;
          end
        end
        REQ: r_state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            r_pc <= r_pc + ADDR_W'(1);
            if (w_halt_hit) begin
              r_halted <= 1'b1;
              r_state  <= IDLE;
            end else if (!run) begin
              r_state <= IDLE;
            end else if (w_space_after_push) begin
              r_state <= REQ;
            end else begin
              r_state <= FULL;
            end
          end else begin
            r_state <= WAIT;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            r_state <= run ? REQ : IDLE;
          end else begin
            r_state <= DROP;
          end
        end
        FULL: begin
          if (!run) begin
            r_state <= IDLE;
          end else if (w_space_now) begin
            r_state <= REQ;
          end else begin
            r_state <= FULL;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
